// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Game-flow controller for the Runner renderer. Sits between the keyboard
// decoder and the renderer on the 100 ms game tick. It turns key presses and
// the renderer's gameover flag into the renderer's pause and reset controls,
// and keeps a 4-digit BCD score for the current run plus the best score
// since reset.
//
// Parameters:
//   KEY_JUMP    key code that starts a run from IDLE
//   KEY_RESET   key code that requests a restart; also driven on reset_code
//   KEY_PAUSE   key code that toggles pause
//   RESET_TICKS ticks that reset_code is held at KEY_RESET (legal 1..15)
//
// Ports:
//   clk_100ms   in   1   100 ms game tick, the only clock
//   reset       in   1   synchronous, active-high
//   key_code    in   5   keyboard decoder code, qualified by key_valid
//   key_valid   in   1   high while a key is held
//   gameover    in   1   renderer collision flag, asynchronous
//   pause       out  1   renderer pause input
//   reset_code  out  5   renderer reset input (KEY_RESET in RESTART, else 0)
//   running     out  1   high in RUN
//   state       out  3   IDLE=0, RUN=1, PAUSED=2, OVER=3, RESTART=4
//   score       out 16   BCD score of the current run
//   best        out 16   BCD best score since reset
//   new_best    out  1   one-tick pulse when best is updated
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int KEY_JUMP    = 16,
  parameter int KEY_RESET   = 17,
  parameter int KEY_PAUSE   = 18,
  parameter int RESET_TICKS = 2
) (
  input  logic        clk_100ms,
  input  logic        reset,
  input  logic [4:0]  key_code,
  input  logic        key_valid,
  input  logic        gameover,
  output logic        pause,
  output logic [4:0]  reset_code,
  output logic        running,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic        new_best
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_OVER    = 3'd3,
    ST_RESTART = 3'd4
  } state_t;

  localparam logic [4:0] CODE_JUMP  = 5'(KEY_JUMP);
  localparam logic [4:0] CODE_RESET = 5'(KEY_RESET);
  localparam logic [4:0] CODE_PAUSE = 5'(KEY_PAUSE);
  // Counter value on the last RESTART tick; leaving then gives exactly
  // RESET_TICKS ticks of a nonzero reset_code.
  localparam logic [3:0] LAST_TICK  = 4'(RESET_TICKS - 1);

  state_t      state_reg, state_next;
  logic        key_prev_reg;
  logic        go1_reg, go2_reg;
  logic [3:0]  rst_cnt_reg;
  logic [15:0] score_reg, best_reg;
  logic        new_best_reg;
  logic        pause_reg, running_reg;
  logic [4:0]  reset_code_reg;

  // ---------------------------------------------------------------------------
  // Key press edge detect: one event per key hold, using the code seen on the
  // press tick.
  // ---------------------------------------------------------------------------
  logic press;
  logic jump_press, reset_press, pause_press;

  assign press       = key_valid & ~key_prev_reg;
  assign jump_press  = press & (key_code == CODE_JUMP);
  assign reset_press = press & (key_code == CODE_RESET);
  assign pause_press = press & (key_code == CODE_PAUSE);

  // ---------------------------------------------------------------------------
  // BCD increment with per-digit ripple carry, saturating at 9999.
  // ---------------------------------------------------------------------------
  logic [3:0]  carry;
  logic [15:0] score_inc_raw;
  logic [15:0] score_inc;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit = score_reg[4*gi +: 4];
      assign score_inc_raw[4*gi +: 4] =
        carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] & (digit == 4'd9);
      end
    end
  endgenerate

  assign score_inc = (score_reg == 16'h9999) ? score_reg : score_inc_raw;

  // ---------------------------------------------------------------------------
  // Next-state decode. In RUN the priority is restart, then gameover, then
  // pause; a gameover still pending when pause is taken is seen on resume
  // because go2 stays high.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (jump_press) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (reset_press)      state_next = ST_RESTART;
        else if (go2_reg)     state_next = ST_OVER;
        else if (pause_press) state_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause_press)      state_next = ST_RUN;
        else if (reset_press) state_next = ST_RESTART;
      end
      ST_OVER: begin
        if (reset_press) state_next = ST_RESTART;
      end
      ST_RESTART: begin
        if (rst_cnt_reg == LAST_TICK) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs. Outputs are computed from the
  // next state so they change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      key_prev_reg   <= 1'b0;
      go1_reg        <= 1'b0;
      go2_reg        <= 1'b0;
      rst_cnt_reg    <= 4'd0;
      score_reg      <= 16'h0000;
      best_reg       <= 16'h0000;
      new_best_reg   <= 1'b0;
      pause_reg      <= 1'b1;
      running_reg    <= 1'b0;
      reset_code_reg <= 5'd0;
    end else begin
      key_prev_reg <= key_valid;
      // Two-flop synchronizer for the renderer's gameover flag.
      go1_reg      <= gameover;
      go2_reg      <= go1_reg;
      state_reg    <= state_next;
      new_best_reg <= 1'b0;

      pause_reg      <= (state_next == ST_IDLE) || (state_next == ST_PAUSED);
      running_reg    <= (state_next == ST_RUN);
      reset_code_reg <= (state_next == ST_RESTART) ? CODE_RESET : 5'd0;

      // Restart counter counts ticks already spent in RESTART.
      if ((state_reg == ST_RESTART) && (state_next == ST_RESTART))
        rst_cnt_reg <= rst_cnt_reg + 4'd1;
      else
        rst_cnt_reg <= 4'd0;

      case (state_reg)
        ST_IDLE: begin
          if (state_next == ST_RUN) score_reg <= 16'h0000;
        end
        ST_RUN: begin
          if (state_next == ST_RESTART) begin
            score_reg <= 16'h0000;
          end else begin
            // The tick that leaves RUN for OVER or PAUSED still counts.
            score_reg <= score_inc;
            // Valid BCD orders the same as binary, so a plain compare works.
            if ((state_next == ST_OVER) && (score_inc > best_reg)) begin
              best_reg     <= score_inc;
              new_best_reg <= 1'b1;
            end
          end
        end
        ST_PAUSED, ST_OVER: begin
          if (state_next == ST_RESTART) score_reg <= 16'h0000;
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign pause      = pause_reg;
  assign running    = running_reg;
  assign reset_code = reset_code_reg;
  assign score      = score_reg;
  assign best       = best_reg;
  assign new_best   = new_best_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  logic        clk_100ms = 1'b0;
  logic        reset;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        gameover;
  logic        pause;
  logic [4:0]  reset_code;
  logic        running;
  logic [2:0]  state;
  logic [15:0] score;
  logic [15:0] best;
  logic        new_best;

  game_flow_ctrl #(
    .KEY_JUMP    (16),
    .KEY_RESET   (17),
    .KEY_PAUSE   (18),
    .RESET_TICKS (2)
  ) dut (
    .clk_100ms  (clk_100ms),
    .reset      (reset),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .gameover   (gameover),
    .pause      (pause),
    .reset_code (reset_code),
    .running    (running),
    .state      (state),
    .score      (score),
    .best       (best),
    .new_best   (new_best)
  );

  always #5 clk_100ms = ~clk_100ms;

  int tick = 0;
  always @(posedge clk_100ms) tick <= tick + 1;

  localparam int S_STATE = 0, S_PAUSE = 1, S_RUN = 2, S_RC = 3,
                 S_SCORE = 4, S_BEST = 5, S_NB = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp_v;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int sel, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc   = tick + 1;
    e.sel   = sel;
    e.exp_v = v;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  task automatic exp_ctl(input logic [2:0] st, input logic pz, input logic rn,
                         input logic [4:0] rc, input string tag);
    push(S_STATE, {13'd0, st}, {tag, ".state"});
    push(S_PAUSE, {15'd0, pz}, {tag, ".pause"});
    push(S_RUN,   {15'd0, rn}, {tag, ".running"});
    push(S_RC,    {11'd0, rc}, {tag, ".reset_code"});
  endtask

  task automatic exp_scr(input logic [15:0] sc, input logic [15:0] bs,
                         input logic nb, input string tag);
    push(S_SCORE, sc,          {tag, ".score"});
    push(S_BEST,  bs,          {tag, ".best"});
    push(S_NB,    {15'd0, nb}, {tag, ".new_best"});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_100ms);
  endtask

  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk_100ms);
      while (sb_q.size() > 0 && sb_q[0].cyc <= tick) begin
        e = sb_q.pop_front();
        case (e.sel)
          S_STATE: act = {13'd0, state};
          S_PAUSE: act = {15'd0, pause};
          S_RUN:   act = {15'd0, running};
          S_RC:    act = {11'd0, reset_code};
          S_SCORE: act = score;
          S_BEST:  act = best;
          default: act = {15'd0, new_best};
        endcase
        checks++;
        if (e.cyc != tick || act !== e.exp_v) begin
          errors++;
          $display("FAIL %s: actual=%h required=%h tick=%0d", e.name, act, e.exp_v, tick);
        end else begin
          $display("ok   %s: %h tick=%0d", e.name, act, tick);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 5'd0; gameover = 1'b0;

    exp_ctl(3'd0, 1'b1, 1'b0, 5'd0, "reset");
    exp_scr(16'h0000, 16'h0000, 1'b0, "reset");
    step(1);
    reset = 1'b0;

    key_valid = 1'b1; key_code = 5'd16;
    exp_ctl(3'd1, 1'b0, 1'b1, 5'd0, "jump");
    exp_scr(16'h0000, 16'h0000, 1'b0, "jump");
    step(1);
    key_valid = 1'b0;
    step(24);
    push(S_SCORE, 16'h0025, "run25.score");
    push(S_PAUSE, 16'h0000, "run25.pause");
    step(1);

    step(73);
    push(S_SCORE, 16'h0099, "bcd99");
    step(1);
    push(S_SCORE, 16'h0100, "bcd100");
    step(1);

    key_valid = 1'b1; key_code = 5'd18;
    for (int i = 0; i < 5; i++) begin
      exp_ctl(3'd2, 1'b1, 1'b0, 5'd0, "pause_hold");
      push(S_SCORE, 16'h0101, "pause_hold.score");
      step(1);
    end
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(S_STATE, 16'd2, "paused.state");
      push(S_SCORE, 16'h0101, "paused.score");
      step(1);
    end
    key_valid = 1'b1; key_code = 5'd18;
    exp_ctl(3'd1, 1'b0, 1'b1, 5'd0, "resume");
    push(S_SCORE, 16'h0101, "resume.score");
    step(1);
    key_valid = 1'b0;
    push(S_SCORE, 16'h0102, "resume_count");
    step(1);

    gameover = 1'b1;
    push(S_STATE, 16'd1, "go_k.state");
    push(S_SCORE, 16'h0103, "go_k.score");
    step(1);
    push(S_STATE, 16'd1, "go_k1.state");
    push(S_SCORE, 16'h0104, "go_k1.score");
    step(1);
    exp_ctl(3'd3, 1'b0, 1'b0, 5'd0, "over");
    exp_scr(16'h0105, 16'h0105, 1'b1, "over");
    step(1);
    push(S_STATE, 16'd3, "over_next.state");
    exp_scr(16'h0105, 16'h0105, 1'b0, "over_next");
    step(1);

    gameover = 1'b0;
    key_valid = 1'b1; key_code = 5'd17;
    exp_ctl(3'd4, 1'b0, 1'b0, 5'd17, "restart0");
    exp_scr(16'h0000, 16'h0105, 1'b0, "restart0");
    step(1);
    key_valid = 1'b0;
    exp_ctl(3'd4, 1'b0, 1'b0, 5'd17, "restart1");
    step(1);
    exp_ctl(3'd0, 1'b1, 1'b0, 5'd0, "restart_idle");
    push(S_BEST, 16'h0105, "restart_idle.best");
    step(1);

    key_valid = 1'b1; key_code = 5'd16;
    push(S_STATE, 16'd1, "run2.state");
    step(1);
    key_valid = 1'b0;
    step(2);
    gameover = 1'b1;
    step(2);
    exp_ctl(3'd3, 1'b0, 1'b0, 5'd0, "over2");
    exp_scr(16'h0005, 16'h0105, 1'b0, "over2");
    step(1);
    push(S_NB, 16'd0, "over2_next.new_best");
    push(S_BEST, 16'h0105, "over2_next.best");
    step(1);

    gameover = 1'b0;
    key_valid = 1'b1; key_code = 5'd17;
    exp_ctl(3'd4, 1'b0, 1'b0, 5'd17, "restart_b");
    step(1);
    key_valid = 1'b0; reset = 1'b1;
    exp_ctl(3'd0, 1'b1, 1'b0, 5'd0, "mid_reset");
    exp_scr(16'h0000, 16'h0000, 1'b0, "mid_reset");
    step(1);
    reset = 1'b0;

    key_valid = 1'b1; key_code = 5'd16;
    push(S_STATE, 16'd1, "run3.state");
    step(1);
    key_valid = 1'b0; gameover = 1'b1;
    step(2);
    key_valid = 1'b1; key_code = 5'd17;
    exp_ctl(3'd4, 1'b0, 1'b0, 5'd17, "simul");
    exp_scr(16'h0000, 16'h0000, 1'b0, "simul");
    step(1);
    key_valid = 1'b0; gameover = 1'b0;
    push(S_STATE, 16'd4, "simul_next.state");
    push(S_NB, 16'd0, "simul_next.new_best");
    push(S_BEST, 16'h0000, "simul_next.best");
    step(1);

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    key_valid = 1'b1; key_code = 5'd16;
    push(S_STATE, 16'd1, "run4.state");
    step(1);
    key_valid = 1'b0;
    step(998);
    push(S_SCORE, 16'h0999, "bcd999");
    step(1);
    push(S_SCORE, 16'h1000, "bcd1000");
    step(1);
    step(8998);
    push(S_SCORE, 16'h9999, "sat0");
    step(1);
    push(S_SCORE, 16'h9999, "sat1");
    step(1);
    push(S_SCORE, 16'h9999, "sat2");
    push(S_STATE, 16'd1, "sat2.state");
    step(1);

    step(2);
    #1;

    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL final.state: actual=%h required=%h", state, 3'd1);
    end else begin
      $display("ok   final.state: %h", state);
    end
    checks++;
    if (score !== 16'h9999) begin
      errors++;
      $display("FAIL final.score: actual=%h required=%h", score, 16'h9999);
    end else begin
      $display("ok   final.score: %h", score);
    end
    checks++;
    if (best !== 16'h0000) begin
      errors++;
      $display("FAIL final.best: actual=%h required=%h", best, 16'h0000);
    end else begin
      $display("ok   final.best: %h", best);
    end
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL final.running: actual=%h required=%h", running, 1'b1);
    end else begin
      $display("ok   final.running: %h", running);
    end
    checks++;
    if (reset_code !== 5'd0) begin
      errors++;
      $display("FAIL final.reset_code: actual=%h required=%h", reset_code, 5'd0);
    end else begin
      $display("ok   final.reset_code: %h", reset_code);
    end

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: actual=never-compared required=%h tick=%0d", e.name, e.exp_v, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-flow controller driving the Runner renderer's control inputs: it decodes keyboard codes and the renderer's `gameover` flag into `pause` and a held `reset_code`, and maintains a BCD score and best score. It runs on the 100 ms tick, between the keyboard decoder and the renderer, and feeds the score display. It consumes `gameover` and produces the renderer's `pause` and `reset` inputs.

## Interface
- `KEY_JUMP`, default 16: key code that starts a run from IDLE.
- `KEY_RESET`, default 17: key code that requests a restart; also the value driven on `reset_code`.
- `KEY_PAUSE`, default 18: key code that toggles pause.
- `RESET_TICKS`, default 2: number of clk_100ms ticks that `reset_code` is held at `KEY_RESET`; legal range 1..15.

- `clk_100ms`  in  1  100 ms game tick; the only clock in this block.
- `reset`  in  1  Synchronous, active-high.
- `key_code`  in  5  Keyboard decoder code; qualified by `key_valid`.
- `key_valid`  in  1  High while a key is held.
- `gameover`  in  1  Renderer collision flag; asynchronous to `clk_100ms`.
- `pause`  out  1  To the renderer's `pause` input.
- `reset_code`  out  5  To the renderer's `reset` input; `KEY_RESET` during RESTART, else 0.
- `running`  out  1  High in RUN.
- `state`  out  3  Encoded state: IDLE=0, RUN=1, PAUSED=2, OVER=3, RESTART=4.
- `score`  out  16  4-digit BCD score of the current run.
- `best`  out  16  4-digit BCD best score since `reset`.
- `new_best`  out  1  One-tick pulse when `best` is updated.

## Operation
- Key press event: `press = key_valid & ~key_prev`, where `key_prev` is registered each tick. The code used is `key_code` on that tick. Holding a key generates exactly one event.
- Gameover synchronizer: two flops (`go1`, `go2`). Only `go2` is used.
- IDLE:
  - Outputs: `pause`=1, `running`=0, `reset_code`=0.
  - JUMP press → RUN and `score` cleared to 0000.
  - All other inputs are ignored, including `go2`.
- RUN:
  - Outputs: `pause`=0, `running`=1.
  - Priority: RESET press → RESTART; else `go2`=1 → OVER; else PAUSE press → PAUSED.
  - `score` increments by 1 BCD on every tick spent in RUN, including the tick that leaves RUN.
  - `score` saturates at 9999.
- PAUSED:
  - Outputs: `pause`=1; `score` frozen.
  - PAUSE press → RUN. RESET press → RESTART. `go2` is ignored.
- OVER:
  - Outputs: `pause`=0 (the renderer freezes itself on gameover); `score` frozen.
  - RESET press → RESTART. All other inputs are ignored.
- Entry to OVER: if `score` > `best` (compared after the final increment), then `best`←`score` and `new_best`=1 for one tick.
- RESTART:
  - Outputs: `reset_code`=`KEY_RESET`, `pause`=0; `score`=0000 on entry.
  - An internal 4-bit counter runs from 0. After exactly `RESET_TICKS` ticks in RESTART → IDLE.
  - Key presses and `go2` are ignored.
- BCD arithmetic: per-digit carry; a digit of 9 plus 1 gives 0 and carries into the next digit. Digits never hold 10..15.

## Timing
- Reset values:
  - `state`=IDLE, `pause`=1, `reset_code`=0, `running`=0.
  - `score`=0000, `best`=0000, `new_best`=0.
  - `key_prev`=0, `go1`=`go2`=0, restart counter 0.
  - `reset` overrides everything, including mid-RESTART, where `reset_code` drops to 0 on the next edge.
- All outputs are registered or decoded from registers. A state change is visible immediately after the edge on which it occurs.
- Key latency: a press sampled at edge n changes `state` and outputs at edge n.
- Gameover latency: `gameover` rising before edge k gives `go2`=1 after edge k+1 and OVER after edge k+2. `score` still increments at edges k, k+1 and k+2.
- `reset_code` is nonzero for exactly `RESET_TICKS` consecutive ticks per restart. The renderer samples it on its faster clocks.
- Simultaneous events in RUN: RESET > gameover > PAUSE. A gameover that is pending when pause is taken is acted on when RUN resumes.

## Test plan
- Reset, then JUMP press (code 16, one tick) → IDLE→RUN; after 25 ticks `score`=0x0025 and `pause`=0.
- In RUN with `score`=0x0099, one more tick → 0x0100. Preload 0x9999 → stays 0x9999.
- In RUN, `gameover` rises before edge k → `state`=OVER after edge k+2 with `score` incremented 3 more times; `best` updated and `new_best` high for exactly one tick. A second run with a lower score → `best` unchanged, no pulse.
- PAUSE press in RUN → `pause`=1 and `score` frozen for 10 ticks. PAUSE again → RUN resumes counting. Holding `key_valid` for 5 ticks causes only one toggle.
- RESET press in OVER with `RESET_TICKS`=2 → `reset_code`=17 for exactly 2 ticks, `score`=0000, then IDLE with `reset_code`=0. Assert `reset` mid-RESTART → IDLE on the next edge with `reset_code`=0.
- Same tick in RUN with RESET press and `go2`=1 → RESTART taken, `best` not updated.
